cv32e40p_xif_coproc_router: RTL and testbench
=============================================

Name: cv32e40p_xif_coproc_router

Overview:
- Connects one cv32e40p CORE-V-XIF master to NUM_COPROC coprocessors, for example fpu_ss plus further accelerators.
- Broadcasts issue offers to all coprocessors and merges their responses.
- Tracks which coprocessor owns each in-flight instruction ID, routes commits to that owner only, and round-robin arbitrates coprocessor results back to the core.
- Sits between cv32e40p_wrapper and the coprocessor instances inside the core-and-coprocessor wrapper.

Parameters:
NUM_COPROC, 2, number of attached coprocessors (1..8)
ID_WIDTH, 4, XIF instruction ID width; ownership table holds 2**ID_WIDTH entries
DATA_WIDTH, 32, result data width

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low
x_issue_valid_i  in  1  core issue request valid
x_issue_ready_o  out  1  issue handshake complete
x_issue_instr_i  in  32  offered instruction
x_issue_id_i  in  ID_WIDTH  offered instruction ID
x_issue_accept_o  out  1  merged accept
x_issue_writeback_o  out  1  merged writeback flag
cp_issue_valid_o  out  NUM_COPROC  per-coprocessor issue valid
cp_issue_ready_i  in  NUM_COPROC  per-coprocessor issue ready
cp_issue_accept_i  in  NUM_COPROC  per-coprocessor accept
cp_issue_writeback_i  in  NUM_COPROC  per-coprocessor writeback flag
cp_issue_instr_o  out  32  broadcast instruction
cp_issue_id_o  out  ID_WIDTH  broadcast ID
x_commit_valid_i  in  1  core commit valid
x_commit_id_i  in  ID_WIDTH  commit ID
x_commit_kill_i  in  1  commit kill
cp_commit_valid_o  out  NUM_COPROC  commit valid, owner only
cp_commit_id_o  out  ID_WIDTH  broadcast commit ID
cp_commit_kill_o  out  1  broadcast kill
cp_result_valid_i  in  NUM_COPROC  result valid
cp_result_ready_o  out  NUM_COPROC  result ready
cp_result_id_i  in  NUM_COPROC*ID_WIDTH  packed result IDs
cp_result_data_i  in  NUM_COPROC*DATA_WIDTH  packed result data
cp_result_rd_i  in  NUM_COPROC*5  packed destination register indices
cp_result_we_i  in  NUM_COPROC  result write enable
x_result_valid_o  out  1  result to core valid
x_result_ready_i  in  1  core result ready
x_result_id_o  out  ID_WIDTH  granted result ID
x_result_data_o  out  DATA_WIDTH  granted result data
x_result_rd_o  out  5  granted destination register
x_result_we_o  out  1  granted write enable
outstanding_o  out  ID_WIDTH+1  count of valid ownership entries
multi_accept_err_o  out  1  one-cycle pulse: more than one coprocessor accepted
stray_result_err_o  out  1  one-cycle pulse: result ID not owned by its sender

Behaviour:
- Reset (synchronous, rst_ni=0 at a clock edge):
  - Clears the ownership table, the responded/accept/writeback latches and the grant lock.
  - Sets the round-robin pointer to 0.
  - All outputs are 0 in the cycle after reset. Reset mid-transaction drops that transaction; no commit or result is replayed.
- Issue, two states IDLE/COLLECT:
  - Stall: if x_issue_valid_i=1 and owner_valid[x_issue_id_i]=1, then cp_issue_valid_o=0 and x_issue_ready_o=0.
  - Otherwise cp_issue_valid_o[i] = x_issue_valid_i & ~responded[i].
  - A coprocessor completes when cp_issue_ready_i[i]=1. Its accept and writeback flags are latched and responded[i] is set.
  - x_issue_ready_o=1 combinationally in the cycle where every coprocessor is responded or completing now. Latency is 0 cycles if all are ready at once.
  - x_issue_accept_o = OR of all accepts, latched and current.
  - x_issue_writeback_o = writeback of the owner, where the owner is the lowest-index accepter.
- Ownership:
  - Latches clear on core handshake.
  - On handshake with accept: owner_valid[id]=1, owner_idx[id] = lowest-index accepter.
  - If more than one coprocessor accepted, multi_accept_err_o pulses in the cycle after the handshake.
  - outstanding_o tracks the number of valid entries, with set and clear in the same cycle netting to 0.
- Commit: single-cycle and unbuffered.
  - cp_commit_valid_o[owner_idx[id]] = x_commit_valid_i & owner_valid[id]. A commit for an unowned ID is dropped.
  - Kill, or writeback=0 recorded at issue: the entry clears at the clock edge.
  - Writeback=1: the entry clears on result handshake.
  - Commit and issue of the same ID in the same cycle: the clear applies and the new issue still stalls that cycle.
- Result:
  - Round-robin arbitration over cp_result_valid_i, starting at the pointer.
  - The grant locks while x_result_valid_o & ~x_result_ready_i, so the payload is held stable.
  - cp_result_ready_o[g] = x_result_ready_i for the granted index g; all others are 0.
  - On handshake: pointer = g+1 mod NUM_COPROC, and owner_valid[id] clears.
  - stray_result_err_o pulses if owner_valid[id]=0 or owner_idx[id]≠g; the result is still forwarded.
  - Result ID is 0 bits of latency; combinational path from valid to core.

Test Plan:
- Coprocessor 0 ready immediately with accept=1, coprocessor 1 ready 2 cycles later with accept=0, ID 3 → x_issue_ready_o high in cycle 2 only, accept=1, outstanding_o=1, owner_idx[3]=0.
- Issue ID 3 again while owned → no cp_issue_valid_o, x_issue_ready_o stays 0; after kill commit of ID 3, the issue proceeds next cycle and outstanding_o returns to 0 then to 1.
- Both coprocessors accept ID 5 → owner=0, multi_accept_err_o pulses once, commit of ID 5 asserts only cp_commit_valid_o[0].
- Both coprocessors present results continuously, x_result_ready_i=1 → grants alternate 0,1,0,1; with ready held low 3 cycles, data and ID stay stable and the grant does not change.
- Coprocessor 1 returns ID 7 that it does not own → forwarded, stray_result_err_o pulses.
- Assert rst_ni=0 mid-COLLECT and with 2 entries outstanding → next cycle all outputs 0, outstanding_o=0, pointer=0.

Source files
------------

// File: rtl/cv32e40p_xif_coproc_router.sv
// CORE-V-XIF router: one cv32e40p master fanned out to NUM_COPROC coprocessors.
// Issue offers are broadcast and their responses merged; commits are routed to the owner; results are round-robin merged.

module cv32e40p_xif_cp_slot (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic issue_go_i,
   input  logic issue_hs_i,
   input  logic ready_i,
   input  logic accept_i,
   input  logic writeback_i,
   output logic valid_o,
   output logic done_o,
   output logic acc_o,
   output logic wb_o
);
   logic responded_q, acc_q, wb_q, done_now;

   assign valid_o  = issue_go_i & ~responded_q;
   assign done_now = valid_o & ready_i;
   assign done_o   = responded_q | done_now;
   assign acc_o    = acc_q | (done_now & accept_i);
   assign wb_o     = wb_q | (done_now & writeback_i);

   always_ff @(posedge clk_i) begin
      if (!rst_ni || issue_hs_i) begin
         responded_q <= 1'b0;
         acc_q       <= 1'b0;
         wb_q        <= 1'b0;
      end else if (done_now) begin
         responded_q <= 1'b1;
         acc_q       <= acc_o;
         wb_q        <= wb_o;
      end
   end
endmodule

module cv32e40p_xif_coproc_router #(
   parameter int NUM_COPROC = 2,
   parameter int ID_WIDTH   = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             x_issue_valid_i,
   output logic                             x_issue_ready_o,
   input  logic [31:0]                      x_issue_instr_i,
   input  logic [ID_WIDTH-1:0]              x_issue_id_i,
   output logic                             x_issue_accept_o,
   output logic                             x_issue_writeback_o,
   output logic [NUM_COPROC-1:0]            cp_issue_valid_o,
   input  logic [NUM_COPROC-1:0]            cp_issue_ready_i,
   input  logic [NUM_COPROC-1:0]            cp_issue_accept_i,
   input  logic [NUM_COPROC-1:0]            cp_issue_writeback_i,
   output logic [31:0]                      cp_issue_instr_o,
   output logic [ID_WIDTH-1:0]              cp_issue_id_o,
   input  logic                             x_commit_valid_i,
   input  logic [ID_WIDTH-1:0]              x_commit_id_i,
   input  logic                             x_commit_kill_i,
   output logic [NUM_COPROC-1:0]            cp_commit_valid_o,
   output logic [ID_WIDTH-1:0]              cp_commit_id_o,
   output logic                             cp_commit_kill_o,
   input  logic [NUM_COPROC-1:0]            cp_result_valid_i,
   output logic [NUM_COPROC-1:0]            cp_result_ready_o,
   input  logic [NUM_COPROC*ID_WIDTH-1:0]   cp_result_id_i,
   input  logic [NUM_COPROC*DATA_WIDTH-1:0] cp_result_data_i,
   input  logic [NUM_COPROC*5-1:0]          cp_result_rd_i,
   input  logic [NUM_COPROC-1:0]            cp_result_we_i,
   output logic                             x_result_valid_o,
   input  logic                             x_result_ready_i,
   output logic [ID_WIDTH-1:0]              x_result_id_o,
   output logic [DATA_WIDTH-1:0]            x_result_data_o,
   output logic [4:0]                       x_result_rd_o,
   output logic                             x_result_we_o,
   output logic [ID_WIDTH:0]                outstanding_o,
   output logic                             multi_accept_err_o,
   output logic                             stray_result_err_o
);
   localparam int DEPTH = 2**ID_WIDTH;
   localparam int CW    = (NUM_COPROC > 1) ? $clog2(NUM_COPROC) : 1;

   typedef logic [CW-1:0] cidx_t;
   typedef struct packed {
      logic [ID_WIDTH-1:0]   id;
      logic [DATA_WIDTH-1:0] data;
      logic [4:0]            rd;
      logic                  we;
   } res_t;
   typedef enum logic {IDLE, COLLECT} issue_state_e;

   // ownership table
   logic [DEPTH-1:0]         owner_valid_q, owner_valid_d, owner_wb_q;
   logic [DEPTH-1:0][CW-1:0] owner_idx_q;
   logic [ID_WIDTH:0]        outstanding_q, cnt_d;

   // issue
   issue_state_e          state_q, state_d;
   logic                  issue_go, all_done, issue_hs, issue_own;
   logic [NUM_COPROC-1:0] done, acc_all, wb_all;
   cidx_t                 owner_sel;

   assign issue_go = x_issue_valid_i & ~owner_valid_q[x_issue_id_i];

   for (genvar i = 0; i < NUM_COPROC; i++) begin : g_slot
      cv32e40p_xif_cp_slot u_slot (
         .clk_i       (clk_i),
         .rst_ni      (rst_ni),
         .issue_go_i  (issue_go),
         .issue_hs_i  (issue_hs),
         .ready_i     (cp_issue_ready_i[i]),
         .accept_i    (cp_issue_accept_i[i]),
         .writeback_i (cp_issue_writeback_i[i]),
         .valid_o     (cp_issue_valid_o[i]),
         .done_o      (done[i]),
         .acc_o       (acc_all[i]),
         .wb_o        (wb_all[i])
      );
   end

   assign all_done            = &done;
   assign x_issue_ready_o     = issue_go & all_done;
   assign issue_hs            = x_issue_ready_o;
   assign issue_own           = issue_hs & (|acc_all);
   assign x_issue_accept_o    = |acc_all;
   assign x_issue_writeback_o = (|acc_all) & wb_all[owner_sel];
   assign cp_issue_instr_o    = x_issue_instr_i;
   assign cp_issue_id_o       = x_issue_id_i;

   // lowest-index accepter owns the instruction
   always_comb begin
      owner_sel = '0;
      for (int i = NUM_COPROC-1; i >= 0; i--)
         if (acc_all[i]) owner_sel = cidx_t'(i);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (issue_go && !all_done) state_d = COLLECT;
         COLLECT: if (issue_hs) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // commit
   logic commit_hit, commit_clr;

   assign commit_hit       = x_commit_valid_i & owner_valid_q[x_commit_id_i];
   assign commit_clr       = commit_hit & (x_commit_kill_i | ~owner_wb_q[x_commit_id_i]);
   assign cp_commit_id_o   = x_commit_id_i;
   assign cp_commit_kill_o = x_commit_kill_i;

   for (genvar i = 0; i < NUM_COPROC; i++) begin : g_commit
      assign cp_commit_valid_o[i] = commit_hit & (owner_idx_q[x_commit_id_i] == cidx_t'(i));
   end

   // result arbitration
   res_t [NUM_COPROC-1:0] res;
   res_t                  gres;
   cidx_t                 ptr_q, lock_idx_q, grant;
   logic                  lock_q, rvalid, found, res_hs, stray_d;

   for (genvar i = 0; i < NUM_COPROC; i++) begin : g_res
      assign res[i].id   = cp_result_id_i[i*ID_WIDTH +: ID_WIDTH];
      assign res[i].data = cp_result_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      assign res[i].rd   = cp_result_rd_i[i*5 +: 5];
      assign res[i].we   = cp_result_we_i[i];
      assign cp_result_ready_o[i] = rvalid & x_result_ready_i & (grant == cidx_t'(i));
   end

   always_comb begin
      int j;
      j     = 0;
      grant = ptr_q;
      found = 1'b0;
      for (int k = 0; k < NUM_COPROC; k++) begin
         j = int'(ptr_q) + k;
         if (j >= NUM_COPROC) j = j - NUM_COPROC;
         if (!found && cp_result_valid_i[j]) begin
            grant = cidx_t'(j);
            found = 1'b1;
         end
      end
      rvalid = found;
      // a stalled grant holds its index so the payload cannot switch under the core
      if (lock_q) begin
         grant  = lock_idx_q;
         rvalid = cp_result_valid_i[lock_idx_q];
      end
   end

   assign gres             = rvalid ? res[grant] : '0;
   assign x_result_valid_o = rvalid;
   assign x_result_id_o    = gres.id;
   assign x_result_data_o  = gres.data;
   assign x_result_rd_o    = gres.rd;
   assign x_result_we_o    = gres.we;
   assign res_hs           = rvalid & x_result_ready_i;
   assign stray_d          = res_hs & (~owner_valid_q[gres.id] | (owner_idx_q[gres.id] != grant));

   // issue set is applied last so it survives a same-cycle clear of that slot
   always_comb begin
      owner_valid_d = owner_valid_q;
      if (commit_clr) owner_valid_d[x_commit_id_i] = 1'b0;
      if (res_hs)     owner_valid_d[gres.id]       = 1'b0;
      if (issue_own)  owner_valid_d[x_issue_id_i]  = 1'b1;
      cnt_d = '0;
      for (int e = 0; e < DEPTH; e++)
         cnt_d = cnt_d + (ID_WIDTH+1)'(owner_valid_d[e]);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         owner_valid_q      <= '0;
         owner_wb_q         <= '0;
         owner_idx_q        <= '0;
         outstanding_q      <= '0;
         ptr_q              <= '0;
         lock_q             <= 1'b0;
         lock_idx_q         <= '0;
         multi_accept_err_o <= 1'b0;
         stray_result_err_o <= 1'b0;
      end else begin
         owner_valid_q <= owner_valid_d;
         outstanding_q <= cnt_d;
         if (issue_own) begin
            owner_idx_q[x_issue_id_i] <= owner_sel;
            owner_wb_q[x_issue_id_i]  <= x_issue_writeback_o;
         end
         lock_q     <= rvalid & ~x_result_ready_i;
         lock_idx_q <= grant;
         if (res_hs)
            ptr_q <= (grant == cidx_t'(NUM_COPROC-1)) ? '0 : grant + cidx_t'(1);
         multi_accept_err_o <= issue_hs & (|(acc_all & (acc_all - NUM_COPROC'(1))));
         stray_result_err_o <= stray_d;
      end
   end

   assign outstanding_o = outstanding_q;

endmodule

// File: tb/tb_cv32e40p_xif_coproc_router.sv
// Directed bench for cv32e40p_xif_coproc_router with two coprocessors and hand-computed expectations.

module tb_cv32e40p_xif_coproc_router;
   localparam int N   = 2;
   localparam int IDW = 4;
   localparam int DW  = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_ni;
   logic            x_issue_valid_i, x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o;
   logic [31:0]     x_issue_instr_i, cp_issue_instr_o;
   logic [IDW-1:0]  x_issue_id_i, cp_issue_id_o;
   logic [N-1:0]    cp_issue_valid_o, cp_issue_ready_i, cp_issue_accept_i, cp_issue_writeback_i;
   logic            x_commit_valid_i, x_commit_kill_i, cp_commit_kill_o;
   logic [IDW-1:0]  x_commit_id_i, cp_commit_id_o;
   logic [N-1:0]    cp_commit_valid_o;
   logic [N-1:0]    cp_result_valid_i, cp_result_ready_o, cp_result_we_i;
   logic [N*IDW-1:0] cp_result_id_i;
   logic [N*DW-1:0] cp_result_data_i;
   logic [N*5-1:0]  cp_result_rd_i;
   logic            x_result_valid_o, x_result_ready_i, x_result_we_o;
   logic [IDW-1:0]  x_result_id_o;
   logic [DW-1:0]   x_result_data_o;
   logic [4:0]      x_result_rd_o;
   logic [IDW:0]    outstanding_o;
   logic            multi_accept_err_o, stray_result_err_o;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] D0 = 32'hA0A0_0000;
   localparam logic [31:0] D1 = 32'hB1B1_1111;

   cv32e40p_xif_coproc_router #(.NUM_COPROC(N), .ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .x_issue_valid_i(x_issue_valid_i), .x_issue_ready_o(x_issue_ready_o),
      .x_issue_instr_i(x_issue_instr_i), .x_issue_id_i(x_issue_id_i),
      .x_issue_accept_o(x_issue_accept_o), .x_issue_writeback_o(x_issue_writeback_o),
      .cp_issue_valid_o(cp_issue_valid_o), .cp_issue_ready_i(cp_issue_ready_i),
      .cp_issue_accept_i(cp_issue_accept_i), .cp_issue_writeback_i(cp_issue_writeback_i),
      .cp_issue_instr_o(cp_issue_instr_o), .cp_issue_id_o(cp_issue_id_o),
      .x_commit_valid_i(x_commit_valid_i), .x_commit_id_i(x_commit_id_i),
      .x_commit_kill_i(x_commit_kill_i), .cp_commit_valid_o(cp_commit_valid_o),
      .cp_commit_id_o(cp_commit_id_o), .cp_commit_kill_o(cp_commit_kill_o),
      .cp_result_valid_i(cp_result_valid_i), .cp_result_ready_o(cp_result_ready_o),
      .cp_result_id_i(cp_result_id_i), .cp_result_data_i(cp_result_data_i),
      .cp_result_rd_i(cp_result_rd_i), .cp_result_we_i(cp_result_we_i),
      .x_result_valid_o(x_result_valid_o), .x_result_ready_i(x_result_ready_i),
      .x_result_id_o(x_result_id_o), .x_result_data_o(x_result_data_o),
      .x_result_rd_o(x_result_rd_o), .x_result_we_o(x_result_we_o),
      .outstanding_o(outstanding_o), .multi_accept_err_o(multi_accept_err_o),
      .stray_result_err_o(stray_result_err_o)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      x_issue_valid_i = 0; x_issue_instr_i = '0; x_issue_id_i = '0;
      cp_issue_ready_i = '0; cp_issue_accept_i = '0; cp_issue_writeback_i = '0;
      x_commit_valid_i = 0; x_commit_id_i = '0; x_commit_kill_i = 0;
      cp_result_valid_i = '0; cp_result_id_i = '0; cp_result_data_i = '0;
      cp_result_rd_i = '0; cp_result_we_i = '0; x_result_ready_i = 0;
   endtask

   task automatic issue(input logic [IDW-1:0] id, input logic [N-1:0] rdy,
                        input logic [N-1:0] acc, input logic [N-1:0] wb);
      x_issue_valid_i = 1; x_issue_id_i = id; x_issue_instr_i = 32'h0000_1053 | 32'(id);
      cp_issue_ready_i = rdy; cp_issue_accept_i = acc; cp_issue_writeback_i = wb;
   endtask

   task automatic commit(input logic v, input logic [IDW-1:0] id, input logic kill);
      x_commit_valid_i = v; x_commit_id_i = id; x_commit_kill_i = kill;
   endtask

   task automatic set_res(input int l, input logic v, input logic [IDW-1:0] id,
                          input logic [DW-1:0] d, input logic [4:0] rd, input logic we);
      cp_result_valid_i[l] = v;
      cp_result_id_i[l*IDW +: IDW] = id;
      cp_result_data_i[l*DW +: DW] = d;
      cp_result_rd_i[l*5 +: 5] = rd;
      cp_result_we_i[l] = we;
   endtask

   task automatic test_reset;
      rst_ni = 0; idle_inputs();
      tick(); tick();
      rst_ni = 1; #1;
      checks++; if ({x_issue_ready_o, cp_issue_valid_o, x_issue_accept_o, cp_commit_valid_o} !== '0) begin
         errors++; $display("FAIL reset_issue got=%b exp=0", {x_issue_ready_o, cp_issue_valid_o, x_issue_accept_o, cp_commit_valid_o}); end
      checks++; if ({x_result_valid_o, cp_result_ready_o, x_result_data_o, x_result_id_o} !== '0) begin
         errors++; $display("FAIL reset_result got=%h exp=0", {x_result_valid_o, cp_result_ready_o, x_result_data_o, x_result_id_o}); end
      checks++; if ({outstanding_o, multi_accept_err_o, stray_result_err_o} !== '0) begin
         errors++; $display("FAIL reset_status got=%h exp=0", {outstanding_o, multi_accept_err_o, stray_result_err_o}); end
   endtask

   task automatic test_issue_collect;
      tick(); issue(4'd3, 2'b01, 2'b01, 2'b00); #1;
      checks++; if (cp_issue_valid_o !== 2'b11) begin errors++; $display("FAIL col_c0_valid got=%b exp=11", cp_issue_valid_o); end
      checks++; if (x_issue_ready_o !== 1'b0) begin errors++; $display("FAIL col_c0_ready got=%b exp=0", x_issue_ready_o); end
      checks++; if ({cp_issue_id_o, cp_issue_instr_o} !== {4'd3, 32'h0000_1053}) begin
         errors++; $display("FAIL col_bcast got=%h exp=%h", {cp_issue_id_o, cp_issue_instr_o}, {4'd3, 32'h0000_1053}); end
      tick(); cp_issue_ready_i = 2'b00; cp_issue_accept_i = 2'b00; #1;
      checks++; if (cp_issue_valid_o !== 2'b10) begin errors++; $display("FAIL col_c1_valid got=%b exp=10", cp_issue_valid_o); end
      checks++; if ({x_issue_ready_o, x_issue_accept_o} !== 2'b01) begin errors++; $display("FAIL col_c1_rdyacc got=%b exp=01", {x_issue_ready_o, x_issue_accept_o}); end
      tick(); cp_issue_ready_i = 2'b10; #1;
      checks++; if ({x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o} !== 3'b110) begin
         errors++; $display("FAIL col_c2_hs got=%b exp=110", {x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o}); end
      tick(); idle_inputs(); #1;
      checks++; if (outstanding_o !== 5'd1) begin errors++; $display("FAIL col_outstanding got=%0d exp=1", outstanding_o); end
      checks++; if (x_issue_ready_o !== 1'b0) begin errors++; $display("FAIL col_c3_ready got=%b exp=0", x_issue_ready_o); end
   endtask

   task automatic test_stall;
      tick(); issue(4'd3, 2'b11, 2'b01, 2'b00); #1;
      checks++; if ({cp_issue_valid_o, x_issue_ready_o} !== 3'b000) begin errors++; $display("FAIL stall_c0 got=%b exp=000", {cp_issue_valid_o, x_issue_ready_o}); end
      tick(); commit(1, 4'd3, 1); #1;
      checks++; if ({cp_commit_valid_o, cp_commit_kill_o, cp_commit_id_o} !== {2'b01, 1'b1, 4'd3}) begin
         errors++; $display("FAIL stall_kill_route got=%h exp=%h", {cp_commit_valid_o, cp_commit_kill_o, cp_commit_id_o}, {2'b01, 1'b1, 4'd3}); end
      checks++; if ({cp_issue_valid_o, x_issue_ready_o} !== 3'b000) begin errors++; $display("FAIL stall_same_cycle got=%b exp=000", {cp_issue_valid_o, x_issue_ready_o}); end
      tick(); commit(0, 4'd0, 0); #1;
      checks++; if (outstanding_o !== 5'd0) begin errors++; $display("FAIL stall_cleared got=%0d exp=0", outstanding_o); end
      checks++; if ({cp_issue_valid_o, x_issue_ready_o} !== 3'b111) begin errors++; $display("FAIL stall_proceed got=%b exp=111", {cp_issue_valid_o, x_issue_ready_o}); end
      tick(); idle_inputs(); #1;
      checks++; if (outstanding_o !== 5'd1) begin errors++; $display("FAIL stall_reissued got=%0d exp=1", outstanding_o); end
      commit(1, 4'd3, 0);
      tick(); commit(0, 4'd0, 0); #1;
      checks++; if (outstanding_o !== 5'd0) begin errors++; $display("FAIL stall_nowb_commit got=%0d exp=0", outstanding_o); end
   endtask

   task automatic test_multi_accept;
      tick(); issue(4'd5, 2'b11, 2'b11, 2'b10); #1;
      checks++; if ({x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o} !== 3'b110) begin
         errors++; $display("FAIL multi_hs got=%b exp=110", {x_issue_ready_o, x_issue_accept_o, x_issue_writeback_o}); end
      tick(); idle_inputs(); #1;
      checks++; if ({multi_accept_err_o, outstanding_o} !== {1'b1, 5'd1}) begin
         errors++; $display("FAIL multi_pulse got=%h exp=%h", {multi_accept_err_o, outstanding_o}, {1'b1, 5'd1}); end
      tick(); commit(1, 4'd5, 0); #1;
      checks++; if (multi_accept_err_o !== 1'b0) begin errors++; $display("FAIL multi_once got=%b exp=0", multi_accept_err_o); end
      checks++; if (cp_commit_valid_o !== 2'b01) begin errors++; $display("FAIL multi_commit_owner got=%b exp=01", cp_commit_valid_o); end
      tick(); commit(0, 4'd0, 0); #1;
      checks++; if (outstanding_o !== 5'd0) begin errors++; $display("FAIL multi_cleared got=%0d exp=0", outstanding_o); end
   endtask

   task automatic test_writeback_result;
      tick(); issue(4'd6, 2'b11, 2'b10, 2'b10); #1;
      checks++; if ({x_issue_ready_o, x_issue_writeback_o} !== 2'b11) begin errors++; $display("FAIL wb_issue got=%b exp=11", {x_issue_ready_o, x_issue_writeback_o}); end
      tick(); idle_inputs(); commit(1, 4'd6, 0); #1;
      checks++; if (cp_commit_valid_o !== 2'b10) begin errors++; $display("FAIL wb_commit_owner got=%b exp=10", cp_commit_valid_o); end
      tick(); commit(0, 4'd0, 0); #1;
      checks++; if (outstanding_o !== 5'd1) begin errors++; $display("FAIL wb_held got=%0d exp=1", outstanding_o); end
      set_res(1, 1, 4'd6, 32'hDEAD_BEEF, 5'd9, 1); x_result_ready_i = 1; #1;
      checks++; if ({x_result_valid_o, x_result_id_o, x_result_data_o, x_result_rd_o, x_result_we_o} !== {1'b1, 4'd6, 32'hDEAD_BEEF, 5'd9, 1'b1}) begin
         errors++; $display("FAIL wb_result got=%h exp=%h", {x_result_valid_o, x_result_id_o, x_result_data_o, x_result_rd_o, x_result_we_o}, {1'b1, 4'd6, 32'hDEAD_BEEF, 5'd9, 1'b1}); end
      checks++; if (cp_result_ready_o !== 2'b10) begin errors++; $display("FAIL wb_ready_route got=%b exp=10", cp_result_ready_o); end
      tick(); idle_inputs(); #1;
      checks++; if ({outstanding_o, stray_result_err_o} !== {5'd0, 1'b0}) begin
         errors++; $display("FAIL wb_result_clear got=%h exp=0", {outstanding_o, stray_result_err_o}); end
   endtask

   task automatic test_round_robin;
      set_res(0, 1, 4'd10, D0, 5'd1, 1); set_res(1, 1, 4'd11, D1, 5'd2, 1); x_result_ready_i = 1;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if (x_result_data_o !== ((k % 2) ? D1 : D0)) begin
            errors++; $display("FAIL rr_grant%0d got=%h exp=%h", k, x_result_data_o, (k % 2) ? D1 : D0); end
         checks++; if (cp_result_ready_o !== ((k % 2) ? 2'b10 : 2'b01)) begin
            errors++; $display("FAIL rr_ready%0d got=%b", k, cp_result_ready_o); end
         tick();
      end
      set_res(0, 0, 4'd10, D0, 5'd1, 1); x_result_ready_i = 0; #1;
      checks++; if ({x_result_valid_o, x_result_data_o, cp_result_ready_o} !== {1'b1, D1, 2'b00}) begin
         errors++; $display("FAIL rr_stall_start got=%h exp=%h", {x_result_valid_o, x_result_data_o, cp_result_ready_o}, {1'b1, D1, 2'b00}); end
      tick(); set_res(0, 1, 4'd10, D0, 5'd1, 1);
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if ({x_result_id_o, x_result_data_o} !== {4'd11, D1}) begin
            errors++; $display("FAIL rr_lock%0d got=%h exp=%h", k, {x_result_id_o, x_result_data_o}, {4'd11, D1}); end
         tick();
      end
      x_result_ready_i = 1; #1;
      checks++; if ({x_result_data_o, cp_result_ready_o} !== {D1, 2'b10}) begin
         errors++; $display("FAIL rr_release got=%h exp=%h", {x_result_data_o, cp_result_ready_o}, {D1, 2'b10}); end
      tick(); #1;
      checks++; if (x_result_data_o !== D0) begin errors++; $display("FAIL rr_after_release got=%h exp=%h", x_result_data_o, D0); end
      tick(); idle_inputs();
   endtask

   task automatic test_stray;
      set_res(1, 1, 4'd7, 32'hC7C7_C7C7, 5'd3, 1); x_result_ready_i = 1; #1;
      checks++; if ({x_result_valid_o, x_result_id_o, x_result_data_o} !== {1'b1, 4'd7, 32'hC7C7_C7C7}) begin
         errors++; $display("FAIL stray_forward got=%h exp=%h", {x_result_valid_o, x_result_id_o, x_result_data_o}, {1'b1, 4'd7, 32'hC7C7_C7C7}); end
      tick(); idle_inputs(); #1;
      checks++; if (stray_result_err_o !== 1'b1) begin errors++; $display("FAIL stray_pulse got=%b exp=1", stray_result_err_o); end
      tick(); #1;
      checks++; if (stray_result_err_o !== 1'b0) begin errors++; $display("FAIL stray_once got=%b exp=0", stray_result_err_o); end
   endtask

   task automatic test_reset_mid;
      tick(); issue(4'd1, 2'b11, 2'b01, 2'b00);
      tick(); issue(4'd2, 2'b11, 2'b10, 2'b10);
      tick(); idle_inputs(); #1;
      checks++; if (outstanding_o !== 5'd2) begin errors++; $display("FAIL rmid_two got=%0d exp=2", outstanding_o); end
      set_res(0, 1, 4'd12, D0, 5'd4, 0); x_result_ready_i = 1;   // pointer moves to 1
      tick(); idle_inputs(); issue(4'd9, 2'b01, 2'b01, 2'b00);
      tick(); rst_ni = 0; idle_inputs();
      tick(); rst_ni = 1; #1;
      checks++; if ({outstanding_o, x_issue_ready_o, cp_issue_valid_o, x_result_valid_o, stray_result_err_o, multi_accept_err_o} !== '0) begin
         errors++; $display("FAIL rmid_zero got=%h exp=0", {outstanding_o, x_issue_ready_o, cp_issue_valid_o, x_result_valid_o, stray_result_err_o, multi_accept_err_o}); end
      issue(4'd1, 2'b10, 2'b00, 2'b00); #1;
      checks++; if ({cp_issue_valid_o, x_issue_ready_o} !== 3'b110) begin
         errors++; $display("FAIL rmid_latches got=%b exp=110", {cp_issue_valid_o, x_issue_ready_o}); end
      tick(); cp_issue_ready_i = 2'b01; #1;
      checks++; if ({x_issue_ready_o, x_issue_accept_o} !== 2'b10) begin
         errors++; $display("FAIL rmid_noaccept got=%b exp=10", {x_issue_ready_o, x_issue_accept_o}); end
      tick(); idle_inputs();
      set_res(0, 1, 4'd13, D0, 5'd5, 1); set_res(1, 1, 4'd14, D1, 5'd6, 1); x_result_ready_i = 1; #1;
      checks++; if ({x_result_data_o, outstanding_o} !== {D0, 5'd0}) begin
         errors++; $display("FAIL rmid_pointer got=%h exp=%h", {x_result_data_o, outstanding_o}, {D0, 5'd0}); end
      tick(); idle_inputs();
   endtask

   initial begin
      test_reset();
      test_issue_collect();
      test_stall();
      test_multi_accept();
      test_writeback_result();
      test_round_robin();
      test_stray();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
